// File: rtl/sim_mmio_monitor_pkg.sv
// rtl/sim_mmio_monitor_pkg.sv - shared widths, state encoding and default MMIO map
package sim_mmio_monitor_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [31:0] DEF_EXIT_ADR     = 32'h0;
    localparam logic [31:0] DEF_CONSOLE_ADR  = 32'h4;
    localparam logic [31:0] DEF_CYCLE_LO_ADR = 32'h8;
    localparam logic [31:0] DEF_CYCLE_HI_ADR = 32'hC;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } mmio_state_t;

endpackage

// File: rtl/sim_mmio_monitor_if.sv
// rtl/sim_mmio_monitor_if.sv - CPU data-port, console and status signals of the MMIO monitor
interface sim_mmio_monitor_if
    import sim_mmio_monitor_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) ();

    logic              r_v;
    logic              w_v;
    logic [XLEN-1:0]   adr;
    logic [XLEN-1:0]   data;
    logic [XLEN/8-1:0] strobe;
    logic              hit;
    logic [XLEN-1:0]   resp;
    logic              resp_v;
    logic [7:0]        con_data;
    logic              con_v;
    logic              con_rdy;
    logic              overflow;
    logic              done;
    logic              timeout;
    logic [XLEN-1:0]   exit_status;

    modport master (
        output r_v, w_v, adr, data, strobe, con_rdy,
        input  hit, resp, resp_v, con_data, con_v, overflow, done, timeout, exit_status
    );

    modport slave (
        input  r_v, w_v, adr, data, strobe, con_rdy,
        output hit, resp, resp_v, con_data, con_v, overflow, done, timeout, exit_status
    );

endinterface

// File: rtl/sim_mmio_monitor_sync_fifo.sv
// rtl/sim_mmio_monitor_sync_fifo.sv - synchronous FIFO with registered head and wrap-bit pointers
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [AW:0]      count;
    logic [AW-1:0]    rd_nxt_idx;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (wr_q == rd_q);
    assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count      = wr_q - rd_q;
    assign rd_nxt_idx = rd_q[AW-1:0] + 1'b1;
    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign do_push    = push_i && (!full_o || pop_i);
    assign do_pop     = pop_i && !empty_o;
    assign head_o     = head_q;

    // Next pointers and next registered head; the head comes from storage
    // unless the entry being pushed is about to become the head.
    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        head_d = head_q;
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
            if (count == (AW+1)'(1)) begin
                if (do_push) begin
                    head_d = push_data_i;
                end
            end else begin
                head_d = mem_q[rd_nxt_idx];
            end
        end else if (empty_o && do_push) begin
            head_d = push_data_i;
        end
    end

    // Pointer and head registers; reset discards contents by emptying the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            head_q <= head_d;
        end
    end

    // Entry storage, no reset needed since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/sim_mmio_monitor.sv
// rtl/sim_mmio_monitor.sv - MMIO exit/console/cycle-counter/watchdog monitor for the CPU bench
module sim_mmio_monitor
    import sim_mmio_monitor_pkg::*;
#(
    parameter int              XLEN           = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] EXIT_ADR       = XLEN'(DEF_EXIT_ADR),
    parameter logic [XLEN-1:0] CONSOLE_ADR    = XLEN'(DEF_CONSOLE_ADR),
    parameter logic [XLEN-1:0] CYCLE_LO_ADR   = XLEN'(DEF_CYCLE_LO_ADR),
    parameter logic [XLEN-1:0] CYCLE_HI_ADR   = XLEN'(DEF_CYCLE_HI_ADR),
    parameter int              FIFO_DEPTH     = 16,
    parameter int              TIMEOUT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    sim_mmio_monitor_if.slave bus
);

    localparam int CW = 2 * XLEN;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    mmio_state_t     state_q, state_d;
    logic [CW-1:0]   cycle_q, cycle_d;
    logic [XLEN-1:0] resp_q, resp_d;
    logic            resp_v_q, resp_v_d;
    logic [XLEN-1:0] exit_status_q, exit_status_d;
    logic            overflow_q, overflow_d;
    logic            timeout_q, timeout_d;

    logic hit_exit, hit_con, hit_lo, hit_hi;
    logic con_push, con_pop, exit_wr, wd_fire, rd_req;
    logic fifo_full, fifo_empty;
    logic unused_strobe;

    assign hit_exit = (bus.adr == EXIT_ADR);
    assign hit_con  = (bus.adr == CONSOLE_ADR);
    assign hit_lo   = (bus.adr == CYCLE_LO_ADR);
    assign hit_hi   = (bus.adr == CYCLE_HI_ADR);
    assign bus.hit  = (bus.r_v || bus.w_v) && (hit_exit || hit_con || hit_lo || hit_hi);

    // Only the low byte lane carries console data.
    assign unused_strobe = ^bus.strobe[XLEN/8-1:1];

    assign con_push = bus.w_v && hit_con && bus.strobe[0] && (state_q != DONE);
    assign con_pop  = !fifo_empty && bus.con_rdy;
    assign exit_wr  = bus.w_v && hit_exit && (state_q == RUN);
    assign wd_fire  = (TIMEOUT_CYCLES != 0) && (state_q == RUN) && (cycle_q == TO_LAST);
    // A simultaneous write wins; the read half of such a request is dropped.
    assign rd_req   = bus.r_v && !bus.w_v && bus.hit;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_con_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (con_push),
        .push_data_i (bus.data[7:0]),
        .pop_i       (con_pop),
        .head_o      (bus.con_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Next state: run/drain/done sequencing, counter, read response and sticky flags.
    always_comb begin
        state_d       = state_q;
        cycle_d       = (state_q == DONE) ? cycle_q : cycle_q + 1'b1;
        resp_v_d      = rd_req;
        resp_d        = '0;
        exit_status_d = exit_status_q;
        overflow_d    = overflow_q || (con_push && fifo_full && !con_pop);
        timeout_d     = timeout_q;

        if (rd_req) begin
            if (hit_lo) begin
                resp_d = cycle_q[XLEN-1:0];
            end else if (hit_hi) begin
                resp_d = cycle_q[CW-1:XLEN];
            end
        end

        case (state_q)
            RUN: begin
                if (exit_wr) begin
                    state_d       = DRAIN;
                    exit_status_d = bus.data;
                end else if (wd_fire) begin
                    state_d       = DRAIN;
                    exit_status_d = '1;
                    timeout_d     = 1'b1;
                end
            end
            DRAIN: begin
                // A byte pushed this cycle still has to drain before finishing.
                if (fifo_empty && !con_push) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            cycle_q       <= '0;
            resp_q        <= '0;
            resp_v_q      <= 1'b0;
            exit_status_q <= '0;
            overflow_q    <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cycle_q       <= cycle_d;
            resp_q        <= resp_d;
            resp_v_q      <= resp_v_d;
            exit_status_q <= exit_status_d;
            overflow_q    <= overflow_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.resp        = resp_q;
    assign bus.resp_v      = resp_v_q;
    assign bus.con_v       = !fifo_empty;
    assign bus.overflow    = overflow_q;
    assign bus.done        = (state_q == DONE);
    assign bus.timeout     = timeout_q;
    assign bus.exit_status = exit_status_q;

    a_no_rw_collision: assert property (@(posedge clk) disable iff (rst) !(bus.r_v && bus.w_v));

endmodule
